uart_tx_sched: RTL and testbench

Two-requester scheduler that shares the single UART transmitter and its baud generator between two byte sources. It arbitrates round-robin between the requesters and programs the baud generator's `bd_rate` select to the granted requester's rate. When the rate changes, it waits a settle interval, then issues a start to the transmitter and holds off until the transmitter reports completion. It sits between the host-side byte producers and the transmitter/baud-generator pair.

---
 rtl/uart_tx_sched.sv | 86 ++++++++
 tb/tb_uart_tx_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter and baud generator; `UART_SCHED_TIMEOUT_EN adds a WAIT watchdog
module uart_tx_sched #(
    parameter int         SETTLE_CYC  = 4,
    parameter logic [1:0] RESET_RATE  = 2'd3,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic [1:0] req0_rate,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic [1:0] req1_rate,
    output logic       req1_ready,
    output logic [1:0] bd_rate,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       grant_id,
    output logic       active,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, SETTLE, START, WAIT} state_t;
    state_t state, state_nx;
    logic rr, grant, take, timeout;
    logic [1:0] sel_rate;
    logic [15:0] cnt;

    if (SETTLE_CYC < 0 || SETTLE_CYC > 255 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("uart_tx_sched: parameter out of range");
    end

    assign grant = (req0_valid && req1_valid) ? rr : req1_valid;
    assign take = reset_n && state == IDLE && (req0_valid || req1_valid);
    assign sel_rate = grant ? req1_rate : req0_rate;
    assign req0_ready = take && !grant;
    assign req1_ready = take && grant;
    assign tx_start = reset_n && state == START && !tx_busy;
    assign active = reset_n && state != IDLE;

`ifdef UART_SCHED_TIMEOUT_EN
    logic err_q;
    // tx_done in the expiry cycle completes normally and suppresses the abort
    assign timeout = state == WAIT && !tx_done && cnt == 16'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) err_q <= reset_n && timeout;
    assign err = reset_n && err_q;
`else
    assign timeout = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = (sel_rate != bd_rate && SETTLE_CYC != 0) ? SETTLE : START;
            SETTLE:  if (cnt == 16'(SETTLE_CYC - 1)) state_nx = START;
            START:   if (!tx_busy) state_nx = WAIT;
            WAIT:    if (tx_done || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cnt restarts on every state change, so it times both SETTLE and WAIT
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            bd_rate <= RESET_RATE;
            tx_data <= '0;
            grant_id <= 1'b0;
            rr <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= (state_nx != state) ? '0 : cnt + 16'd1;
            if (take) begin
                tx_data <= grant ? req1_data : req0_data;
                grant_id <= grant;
                rr <= !grant;
                bd_rate <= sel_rate;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized checks of uart_tx_sched against a transfer-timeline model
module tb_uart_tx_sched;
    localparam int S = 4;
    localparam int TO = 20;

    logic clk = 1'b0, reset_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic [1:0] req0_rate = 2'd3, req1_rate = 2'd3;
    logic tx_busy = 1'b0, tx_done = 1'b0;
    logic req0_ready, req1_ready, tx_start, grant_id, active, err;
    logic [1:0] bd_rate;
    logic [7:0] tx_data;
    int cyc = 0, passed = 0, total = 0;
    logic chk_en = 1'b0;

    uart_tx_sched #(.SETTLE_CYC(S), .RESET_RATE(2'd3), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_rate(req0_rate), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_rate(req1_rate), .req1_ready(req1_ready),
        .bd_rate(bd_rate), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_id(grant_id), .active(active), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Model: a transfer is owned from acceptance until tx_done (or watchdog);
    // the start may fire from m_start_at onward in any cycle the transmitter is idle.
    logic m_xfer = 1'b0, m_wait = 1'b0, m_rr = 1'b0, m_gid = 1'b0, m_err = 1'b0;
    logic [1:0] m_rate = 2'd3;
    logic [7:0] m_data = '0;
    int m_start_at = 0, m_wait_since = 0;

    always @(negedge clk) begin
        logic r0, r1, st, g, to;
        logic [1:0] nr;
        r0 = reset_n && !m_xfer && req0_valid && (!req1_valid || !m_rr);
        r1 = reset_n && !m_xfer && req1_valid && (!req0_valid || m_rr);
        st = reset_n && m_xfer && !m_wait && cyc >= m_start_at && !tx_busy;
        if (chk_en) begin
            chk("m_req0_ready", 32'(req0_ready), 32'(r0));
            chk("m_req1_ready", 32'(req1_ready), 32'(r1));
            chk("m_tx_start", 32'(tx_start), 32'(st));
            chk("m_active", 32'(active), 32'(reset_n && m_xfer));
            chk("m_bd_rate", 32'(bd_rate), 32'(m_rate));
            chk("m_tx_data", 32'(tx_data), 32'(m_data));
            chk("m_grant_id", 32'(grant_id), 32'(m_gid));
            chk("m_err", 32'(err), 32'(reset_n && m_err));
        end
        to = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
        to = m_wait && !tx_done && (cyc - m_wait_since == TO - 1);
`endif
        m_err = reset_n && to;
        if (!reset_n) begin
            m_xfer = 0; m_wait = 0; m_rr = 0; m_gid = 0; m_rate = 2'd3; m_data = '0;
        end else if (r0 || r1) begin
            g = r1;
            nr = g ? req1_rate : req0_rate;
            m_data = g ? req1_data : req0_data;
            m_gid = g;
            m_rr = !g;
            m_start_at = cyc + 1 + (nr != m_rate ? S : 0);
            m_rate = nr;
            m_xfer = 1;
            m_wait = 0;
        end else if (st) begin
            m_wait = 1;
            m_wait_since = cyc + 1;
        end else if (m_wait && (tx_done || to)) begin
            m_xfer = 0;
            m_wait = 0;
        end
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic look(); @(negedge clk); endtask

    task automatic finish_tx(input int n);
        repeat (n) begin step(); tx_busy = 1'b1; end
        step(); tx_busy = 1'b0; tx_done = 1'b1;
        look(); chk("done_active", 32'(active), 1);
        step(); tx_done = 1'b0;
        look(); chk("done_idle", 32'(active), 0);
    endtask

    initial begin
        int got[$];
        int done_at, last_done, r4;
        step(); chk_en = 1'b1;
        repeat (2) step();
        // single byte, unchanged rate
        step(); reset_n = 1'b1; req0_valid = 1'b1; req0_data = 8'h55; req0_rate = 2'd3;
        look(); chk("t1_ready0", 32'(req0_ready), 1); chk("t1_ready1", 32'(req1_ready), 0);
        step(); req0_valid = 1'b0;
        look(); chk("t1_start", 32'(tx_start), 1); chk("t1_bd_rate", 32'(bd_rate), 3);
        chk("t1_data", 32'(tx_data), 32'h55); chk("t1_gid", 32'(grant_id), 0); chk("t1_ready0_low", 32'(req0_ready), 0);
        finish_tx(3);
        // rate change with settle, stray tx_done during SETTLE
        step(); req1_valid = 1'b1; req1_data = 8'hA3; req1_rate = 2'd0;
        look(); chk("t2_ready1", 32'(req1_ready), 1);
        step(); req1_valid = 1'b0;
        look(); chk("t2_bd_rate", 32'(bd_rate), 0); chk("t2_nostart", 32'(tx_start), 0);
        step(); tx_done = 1'b1;
        look(); chk("t2_settle_start", 32'(tx_start), 0);
        step(); tx_done = 1'b0;
        look(); chk("t2_settle_active", 32'(active), 1);
        step(); look(); chk("t2_settle_start2", 32'(tx_start), 0);
        step(); look(); chk("t2_start", 32'(tx_start), 1); chk("t2_data", 32'(tx_data), 32'hA3); chk("t2_gid", 32'(grant_id), 1);
        finish_tx(5);
        // stray tx_done in IDLE
        step(); tx_done = 1'b1;
        look(); chk("idle_stray", 32'(active), 0);
        step(); tx_done = 1'b0;
        look(); chk("idle_stray2", 32'(active), 0);
        // transmitter busy for 3 cycles on entering START
        step(); req0_valid = 1'b1; req0_data = 8'h3C; req0_rate = 2'd0;
        look(); chk("t4_ready0", 32'(req0_ready), 1);
        step(); req0_valid = 1'b0; tx_busy = 1'b1;
        look(); chk("t4_hold1", 32'(tx_start), 0);
        step(); look(); chk("t4_hold2", 32'(tx_start), 0);
        step(); look(); chk("t4_hold3", 32'(tx_start), 0);
        step(); tx_busy = 1'b0;
        look(); chk("t4_start", 32'(tx_start), 1);
        finish_tx(2);
        // both requesters valid, done 10 cycles after each start
        step(); reset_n = 1'b0;
        step(); reset_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_rate = 2'd3; req1_rate = 2'd3; req0_data = 8'h11; req1_data = 8'h22;
        done_at = -1; last_done = -1; r4 = 1 << 30;
        for (int k = 0; k < 200; k++) begin
            look();
            if (req0_ready || req1_ready) begin
                got.push_back(int'(req1_ready));
                if (last_done >= 0) chk("rr_ready_after_done", cyc, last_done + 1);
                if (got.size() == 4) r4 = cyc;
            end
            if (tx_start) done_at = cyc + 10;
            if (tx_done) last_done = cyc;
            if (got.size() >= 4 && last_done > r4 && !active) break;
            step();
            tx_done = (cyc == done_at);
            if (got.size() >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        chk("rr_count", got.size(), 4);
        chk("rr_drained", 32'(last_done > r4), 1);
        for (int i = 0; i < got.size() && i < 4; i++) chk("rr_order", got[i], i % 2);
        // reset during SETTLE
        step(); tx_done = 1'b0; req1_valid = 1'b1; req1_rate = 2'd1;
        look(); chk("r1_ready1", 32'(req1_ready), 1);
        step(); req1_valid = 1'b0;
        look(); chk("r1_bd_rate", 32'(bd_rate), 1);
        step(); reset_n = 1'b0;
        look(); chk("r1_active_in_reset", 32'(active), 0);
        step(); reset_n = 1'b1;
        look(); chk("r1_idle", 32'(active), 0); chk("r1_bd_rate3", 32'(bd_rate), 3); chk("r1_nostart", 32'(tx_start), 0);
        step(); look(); chk("r1_nostart2", 32'(tx_start), 0);
        // reset during WAIT, rr back to 0
        step(); req0_valid = 1'b1; req0_rate = 2'd3;
        look(); chk("r2_ready0", 32'(req0_ready), 1);
        step(); req0_valid = 1'b0;
        look(); chk("r2_start", 32'(tx_start), 1);
        step(); tx_busy = 1'b1;
        look(); chk("r2_wait", 32'(active), 1);
        step(); reset_n = 1'b0;
        step(); reset_n = 1'b1; tx_busy = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        look(); chk("r2_rr_ready0", 32'(req0_ready), 1); chk("r2_rr_ready1", 32'(req1_ready), 0);
        chk("r2_bd_rate", 32'(bd_rate), 3);
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        look(); chk("r2_start2", 32'(tx_start), 1);
        finish_tx(2);
`ifdef UART_SCHED_TIMEOUT_EN
        // watchdog expiry, then tx_done in the expiry cycle
        step(); req0_valid = 1'b1;
        look();
        step(); req0_valid = 1'b0;
        look(); chk("to_start", 32'(tx_start), 1);
        repeat (20) begin step(); look(); chk("to_err_low", 32'(err), 0); end
        step(); look(); chk("to_err", 32'(err), 1); chk("to_idle", 32'(active), 0);
        step(); look(); chk("to_err_pulse", 32'(err), 0);
        step(); req0_valid = 1'b1;
        look();
        step(); req0_valid = 1'b0;
        look();
        repeat (19) begin step(); look(); end
        step(); tx_done = 1'b1;
        look(); chk("tie_active", 32'(active), 1);
        step(); tx_done = 1'b0;
        look(); chk("tie_err", 32'(err), 0); chk("tie_idle", 32'(active), 0);
`endif
        for (int k = 0; k < 4000; k++) begin
            step();
            reset_n = ($urandom_range(0, 299) != 0);
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_data = 8'($urandom);
            req1_data = 8'($urandom);
            req0_rate = 2'($urandom_range(0, 3));
            req1_rate = 2'($urandom_range(0, 3));
            tx_busy = ($urandom_range(0, 3) == 0);
            tx_done = ($urandom_range(0, k < 2000 ? 7 : 40) == 0);
        end
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
